fp_align_controller: RTL
========================

Name: fp_align_controller

Overview:
Multi-cycle exponent-alignment sequencer for the 32-bit floating-point adder. It accepts two IEEE-754 single-precision operands over a valid/ready handshake and computes |eA-eB| and the borrow with a single shared 8-bit subtract step. It then iteratively right-shifts the smaller-exponent mantissa, STEP bits per cycle, and presents aligned mantissas, the common exponent and a sticky bit to the downstream mantissa adder.

Parameters:
STEP, 4, maximum right-shift applied per SHIFT cycle; legal 1..8.

Ports:
clk  input  1  clock, all state changes on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept; equals (state==IDLE) & ~rst
a  input  32  operand A, IEEE-754 single
b  input  32  operand B, IEEE-754 single
out_valid  output  1  aligned result valid
out_ready  input  1  downstream accepts result
exp_out  output  8  larger exponent field
mant_big  output  24  hidden bit & fraction of larger-exponent operand
mant_small  output  24  shifted hidden bit & fraction of smaller-exponent operand
sticky  output  1  OR of all bits shifted out of mant_small
sign_big  output  1  sign of larger-exponent operand
sign_small  output  1  sign of smaller-exponent operand
swap  output  1  1 when eB > eA (B routed to big path)

Behaviour:
- States: IDLE, DIFF, SHIFT, DONE. Registered state and datapath.
- Reset (async): state=IDLE; out_valid, exp_out, mant_big, mant_small, sticky, sign_big, sign_small, swap all 0; internal count 0. Reset mid-operation aborts the operation with no output. in_ready=0 while rst is high.
- Hidden bit = OR of the exponent field (0 for zero/denormal). The exponent field is used as-is; no denormal exponent adjust.
- IDLE: in_ready=1. On in_valid&in_ready, capture a and b, then go to DIFF.
- DIFF, one cycle:
  - d = |eA-eB| (8-bit), borrow = (eA<eB); swap = borrow.
  - Big path = B if swap, else A. Small path = the other operand.
  - Load exp_out, mant_big, sign_big, sign_small. Load mant_small with the unshifted small mantissa. sticky=0.
  - If d==0: go to DONE. Equal exponents give swap=0, no shift.
  - If d>=25: mant_small=0, sticky=OR(small mantissa), go to DONE.
  - Otherwise: count=d, go to SHIFT.
- SHIFT: each cycle shift mant_small right by k=min(count,STEP) and OR the k shifted-out bits into sticky; count-=k. When count reaches 0 after the shift, go to DONE.
- DONE: out_valid=1 with all outputs held stable. in_ready=0; in_valid is ignored. On out_ready, go to IDLE (out_valid=0 next cycle). Outputs keep their last values in IDLE.
- Latency: out_valid rises after the (1 + ceil(d/STEP))-th rising edge following the accepting edge. For d==0 or d>=25 it rises after the 1st edge.
- Throughput: at most one operation in flight. No acceptance occurs in the DONE→IDLE edge cycle.
- The subtract is an 8-bit magnitude difference. No wrap-around of count is possible because count is at most 24.

Test Plan:
- Basic, swap=0: a=0x40400000, b=0x3F800000 -> swap=0, exp_out=0x80, mant_big=0xC00000, mant_small=0x400000, sticky=0. out_valid after the 2nd edge post-accept.
- Basic, swap=1: a=0x3F800000, b=0xC0400000 -> swap=1, exp_out=0x80, mant_big=0xC00000, mant_small=0x400000, sign_big=1, sign_small=0.
- Multi-cycle shift, STEP=4: a=0x45000000, b=0x3F800001 (d=11) -> 3 SHIFT cycles, mant_small=0x001000, sticky=1, out_valid after the 4th edge. Repeat with b=0x3F800000 -> sticky=0.
- Large difference: a=0x4F800000, b=0x3F800000 (d=32) -> no SHIFT state, mant_small=0, sticky=1, out_valid after the 1st edge. Equal exponents a=b=0x3F800000 -> swap=0, mant_small=0x800000.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and a -> outputs unchanged, in_ready=0. Raise out_ready -> out_valid=0 and in_ready=1 next cycle, and a new pair is accepted.
- Reset mid-SHIFT: assert rst during d=11 shifting -> out_valid=0 and all outputs 0 immediately. After release, in_ready=1 and the next operation completes correctly.

Source files
------------

// File: rtl/fp_align_controller.sv
// fp_align_controller
// Multi-cycle exponent-alignment sequencer for the single-precision adder.
// The block accepts an operand pair over a valid/ready handshake. It finds
// the larger exponent with one 8-bit subtract, then shifts the smaller-exponent
// mantissa right by up to STEP bits per cycle. Bits shifted out are folded
// into a sticky bit.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   operand handshake; in_ready = (state==IDLE) & ~rst
//   a, b                IEEE-754 single operands
//   out_valid/out_ready result handshake; out_valid is high while in DONE
//   exp_out             larger exponent field
//   mant_big            hidden bit & fraction of larger-exponent operand
//   mant_small          aligned hidden bit & fraction of smaller-exponent operand
//   sticky              OR of all bits shifted out of mant_small
//   sign_big/sign_small signs of the big/small path operands
//   swap                1 when eB > eA (B routed to big path)
module fp_align_controller #(
    parameter int STEP = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  exp_out,
    output logic [23:0] mant_big,
    output logic [23:0] mant_small,
    output logic        sticky,
    output logic        sign_big,
    output logic        sign_small,
    output logic        swap
);

    typedef enum logic [1:0] {IDLE, DIFF, SHIFT, DONE} state_t;

    localparam logic [4:0] STEP_W = 5'(STEP);

    state_t      state, state_nxt;
    logic [31:0] a_q, b_q;
    logic [4:0]  count;

    // Exponent compare on the captured operands
    logic [7:0]  ea, eb, d;
    logic        borrow;
    logic [23:0] ma, mb;

    // Per-cycle shift amount and the mask of bits it drops
    logic [4:0]  k;
    logic [23:0] out_mask;

    always_comb begin
        ea       = a_q[30:23];
        eb       = b_q[30:23];
        borrow   = (ea < eb);
        d        = borrow ? (eb - ea) : (ea - eb);
        // Hidden bit is 0 for zero/denormal exponent fields
        ma       = {|ea, a_q[22:0]};
        mb       = {|eb, b_q[22:0]};
        k        = (count < STEP_W) ? count : STEP_W;
        out_mask = ~(24'hFFFFFF << k);
    end

    assign in_ready  = (state == IDLE) & ~rst;
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (in_valid) state_nxt = DIFF;
            DIFF: begin
                if (d == 8'd0 || d >= 8'd25) state_nxt = DONE;
                else                         state_nxt = SHIFT;
            end
            // count is nonzero on entry, so k >= 1 and this terminates
            SHIFT: if (count == k) state_nxt = DONE;
            DONE:  if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            count      <= '0;
            exp_out    <= '0;
            mant_big   <= '0;
            mant_small <= '0;
            sticky     <= 1'b0;
            sign_big   <= 1'b0;
            sign_small <= 1'b0;
            swap       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q <= a;
                        b_q <= b;
                    end
                end
                DIFF: begin
                    swap       <= borrow;
                    exp_out    <= borrow ? eb : ea;
                    mant_big   <= borrow ? mb : ma;
                    sign_big   <= borrow ? b_q[31] : a_q[31];
                    sign_small <= borrow ? a_q[31] : b_q[31];
                    if (d >= 8'd25) begin
                        // Everything falls off the end: only the sticky survives
                        mant_small <= '0;
                        sticky     <= borrow ? |ma : |mb;
                        count      <= '0;
                    end else begin
                        mant_small <= borrow ? ma : mb;
                        sticky     <= 1'b0;
                        count      <= d[4:0];
                    end
                end
                SHIFT: begin
                    mant_small <= mant_small >> k;
                    sticky     <= sticky | (|(mant_small & out_mask));
                    count      <= count - k;
                end
                default: ;
            endcase
        end
    end

endmodule
